four_bit_reg_arbiter: RTL and testbench
=======================================

FOUR_BIT_REG_ARBITER -- requirements
Module: four_bit_reg_arbiter

Interface
REQ-001 Parameter: HOLD_CYCLES, default 2, idle cycles after each write during which q is guaranteed stable and no new grant is issued (legal range 0..15).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: req  input  4  per-requester write request, bit i = requester i.
REQ-005 Port: wdata0..wdata3  input  4 each  write data of requester 0..3.
REQ-006 Port: ack  output  4  one-hot, one-cycle write acknowledge to the granted requester.
REQ-007 Port: grant_id  output  2  index of the current or most recent grantee.
REQ-008 Port: busy  output  1  high while in LOAD or HOLD.
REQ-009 Port: q  output  4  shared 4-bit register contents.
REQ-010 Port: q_bar  output  4  bitwise complement of q at all times.
REQ-011 Port: wr_count  output  8  number of completed writes, modulo 256.

Function
REQ-012 The block SHALL implement a 3-state FSM: IDLE, LOAD, HOLD.
REQ-013 IDLE: if req != 0 at a rising edge, the block SHALL register the winner into grant_id and move to LOAD; otherwise it SHALL stay in IDLE.
REQ-014 Arbitration SHALL be round-robin: search starts at rr_ptr and proceeds rr_ptr, rr_ptr+1, ... modulo 4; the first set req bit wins.
REQ-015 LOAD lasts exactly one cycle; ack[grant_id] SHALL be 1 during LOAD and all ack bits SHALL be 0 in every other state.
REQ-016 At the edge ending LOAD, the block SHALL apply these updates: q <= wdata[grant_id]; wr_count <= wr_count+1 (255 wraps to 0); rr_ptr <= grant_id+1 (3 wraps to 0).
REQ-017 At the same edge, the next state SHALL be HOLD with hold counter = HOLD_CYCLES-1, or IDLE if HOLD_CYCLES = 0.
REQ-018 HOLD: the counter SHALL decrement each cycle; at counter = 0 the next state SHALL be IDLE; req SHALL be ignored throughout HOLD.
REQ-019 Latency SHALL be as follows: a request sampled in IDLE at edge k produces ack in cycle k..k+1 and updated q after edge k+1.
REQ-020 The next grant SHALL occur no earlier than edge k+2+HOLD_CYCLES.
REQ-021 Handshake: a requester holds req and wdata stable until it sees ack, then drops req.
REQ-022 A req still high in IDLE after its ack SHALL be treated as a new request at lowest priority.
REQ-023 A req dropped before grant SHALL be ignored with no side effects.
REQ-024 q SHALL change only at the LOAD-exit edge or on reset; q_bar SHALL always equal ~q.
REQ-025 The block SHALL never assert more than one ack bit in any cycle.
REQ-026 grant_id SHALL hold its value outside IDLE-to-LOAD transitions.

Reset
REQ-027 While reset = 1 at a rising edge, the block SHALL set: state IDLE, q = 4'h0, q_bar = 4'hF, grant_id = 0, rr_ptr = 0, wr_count = 0, hold counter = 0, busy = 0.
REQ-028 ack SHALL be forced to 0 in any cycle in which reset = 1, including a cycle in LOAD.
REQ-029 Reset SHALL take priority over all other events; a reset asserted during LOAD SHALL suppress that write.
REQ-030 Under REQ-029, q and wr_count SHALL stay at their reset values, and rr_ptr SHALL NOT advance.
REQ-031 Reset asserted during HOLD SHALL abort the hold and return to IDLE at that edge.

Verification
REQ-032 The bench SHALL cover single write: reset, then req=4'b0100, wdata2=4'hA -> ack=4'b0100 for one cycle; next cycle q=4'hA, q_bar=4'h5, wr_count=1, grant_id=2, busy=1 for 1+HOLD_CYCLES cycles.
REQ-033 The bench SHALL cover round-robin: req=4'b1111 held, each requester dropping its bit after ack, wdataN=N+1 -> grant order 0,1,2,3; q sequence 1,2,3,4; grants spaced 2+HOLD_CYCLES cycles.
REQ-034 The bench SHALL cover fairness: after a grant to 3, req=4'b1001 -> next grant is 0; after a grant to 0, req=4'b1001 -> next grant is 3.
REQ-035 The bench SHALL cover hold blocking: req=4'b0010 asserted during HOLD -> no ack until the state reaches IDLE; ack[1] occurs exactly 1 cycle after IDLE is entered.
REQ-036 The bench SHALL cover reset mid-LOAD: assert reset in the LOAD cycle with wdata0=4'h7 -> ack=0 that cycle, q=4'h0, wr_count=0, rr_ptr=0 afterwards.
REQ-037 The bench SHALL cover wrap with HOLD_CYCLES=0: 256 back-to-back writes from requester 1 -> wr_count returns to 0, a grant every 2 cycles, and q_bar == ~q checked every cycle.

Source files
------------

// File: rtl/four_bit_reg_arbiter.sv
// Round-robin arbiter for four writers sharing one 4-bit register.
// A grant is one LOAD cycle (ack), then HOLD_CYCLES idle cycles before the next grant.
module four_bit_reg_arbiter #(
    parameter int HOLD_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    input  logic [3:0] wdata0,
    input  logic [3:0] wdata1,
    input  logic [3:0] wdata2,
    input  logic [3:0] wdata3,
    output logic [3:0] ack,
    output logic [1:0] grant_id,
    output logic       busy,
    output logic [3:0] q,
    output logic [3:0] q_bar,
    output logic [7:0] wr_count
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    localparam logic [3:0] HOLD_INIT = (HOLD_CYCLES == 0) ? 4'd0 : 4'(HOLD_CYCLES - 1);

    state_t     r_state;
    logic [1:0] r_rr_ptr;
    logic [1:0] r_grant_id;
    logic [3:0] r_hold_cnt;
    logic [3:0] r_q;
    logic [7:0] r_wr_count;

    logic [3:0] w_wdata [4];
    logic [3:0] w_rot_req;
    logic [1:0] w_offset;
    logic [1:0] w_winner;

    assign w_wdata[0] = wdata0;
    assign w_wdata[1] = wdata1;
    assign w_wdata[2] = wdata2;
    assign w_wdata[3] = wdata3;

    // Rotate requests so that bit 0 is the requester rr_ptr points at.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_rot
            logic [1:0] w_idx;
            assign w_idx         = r_rr_ptr + 2'(gi);
            assign w_rot_req[gi] = req[w_idx];
        end
    endgenerate

    always_comb begin
        w_offset = 2'd3;
        if (w_rot_req[0])      w_offset = 2'd0;
        else if (w_rot_req[1]) w_offset = 2'd1;
        else if (w_rot_req[2]) w_offset = 2'd2;
    end

    assign w_winner = r_rr_ptr + w_offset;

    // Ack is gated by reset so a reset landing on LOAD never acknowledges.
    generate
        for (gi = 0; gi < 4; gi++) begin : g_ack
            assign ack[gi] = (r_state == S_LOAD) && !reset && (r_grant_id == 2'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_rr_ptr   <= 2'd0;
            r_grant_id <= 2'd0;
            r_hold_cnt <= 4'd0;
            r_q        <= 4'h0;
            r_wr_count <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (|req) begin
                        r_grant_id <= w_winner;
                        r_state    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_q        <= w_wdata[r_grant_id];
                    r_wr_count <= r_wr_count + 8'd1;
                    r_rr_ptr   <= r_grant_id + 2'd1;
                    r_hold_cnt <= HOLD_INIT;
                    r_state    <= (HOLD_CYCLES == 0) ? S_IDLE : S_HOLD;
                end
                S_HOLD: begin
                    if (r_hold_cnt == 4'd0) r_state <= S_IDLE;
                    else                    r_hold_cnt <= r_hold_cnt - 4'd1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign grant_id = r_grant_id;
    assign busy     = (r_state != S_IDLE);
    assign q        = r_q;
    assign q_bar    = ~r_q;
    assign wr_count = r_wr_count;

endmodule

// File: tb/tb_four_bit_reg_arbiter.sv
// Bench for four_bit_reg_arbiter: directed table, corner sequences, random run
// against a transaction-level model, and a counter-wrap run with HOLD_CYCLES=0.
module tb_four_bit_reg_arbiter;
    localparam int H = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req, wd0, wd1, wd2, wd3;
    logic [3:0] ack0, q0, qb0;
    logic [1:0] gid0;
    logic       busy0;
    logic [7:0] wc0;

    logic       rst1;
    logic [3:0] req1_in, wd1_in;
    logic [3:0] ack1, q1, qb1;
    logic [1:0] gid1;
    logic       busy1;
    logic [7:0] wc1;

    always #5 clk = ~clk;

    four_bit_reg_arbiter #(.HOLD_CYCLES(H)) dut0 (
        .clk(clk), .reset(rst), .req(req),
        .wdata0(wd0), .wdata1(wd1), .wdata2(wd2), .wdata3(wd3),
        .ack(ack0), .grant_id(gid0), .busy(busy0), .q(q0), .q_bar(qb0), .wr_count(wc0)
    );

    four_bit_reg_arbiter #(.HOLD_CYCLES(0)) dut1 (
        .clk(clk), .reset(rst1), .req(req1_in),
        .wdata0(4'h0), .wdata1(wd1_in), .wdata2(4'h0), .wdata3(4'h0),
        .ack(ack1), .grant_id(gid1), .busy(busy1), .q(q1), .q_bar(qb1), .wr_count(wc1)
    );

    int total = 0;
    int bad   = 0;
    int cyc_n = 0;

    // Transaction-level model: a pending write, and a count of edges the
    // arbiter is still blocked for after a write lands.
    bit         m_pend = 1'b0;
    int         m_wait = 0;
    logic [1:0] m_ptr  = 2'd0;
    logic [1:0] m_gid  = 2'd0;
    logic [3:0] m_q    = 4'h0;
    logic [7:0] m_cnt  = 8'd0;

    int         g_id  [$];
    int         g_cyc [$];
    logic [3:0] g_q   [$];

    typedef struct {
        logic [3:0] req;
        logic [3:0] wd2;
        logic [3:0] ack;
        logic [3:0] q;
        logic       busy;
        logic [1:0] gid;
        logic [7:0] wc;
    } vec_t;
    vec_t tv [5];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    task automatic model_step();
        logic [3:0] wd_arr [4];
        bit found;
        wd_arr = '{wd0, wd1, wd2, wd3};
        found  = 1'b0;
        cyc_n++;
        if (rst) begin
            m_pend = 1'b0; m_wait = 0; m_ptr = 2'd0; m_gid = 2'd0; m_q = 4'h0; m_cnt = 8'd0;
        end else if (m_pend) begin
            m_q    = wd_arr[m_gid];
            m_cnt  = 8'((m_cnt + 1) % 256);
            m_ptr  = 2'((m_gid + 1) % 4);
            m_pend = 1'b0;
            m_wait = H;
        end else if (m_wait > 0) begin
            m_wait--;
        end else if (req != 4'b0000) begin
            for (int i = 0; i < 4; i++) begin
                if (!found && req[(m_ptr + i) % 4]) begin
                    m_gid = 2'((m_ptr + i) % 4);
                    found = 1'b1;
                end
            end
            m_pend = 1'b1;
        end
    endtask

    task automatic check_model();
        logic [3:0] e_ack, e_qb;
        e_ack = (m_pend && !rst) ? (4'b0001 << m_gid) : 4'b0000;
        e_qb  = ~m_q;
        chk("model ack", ack0, e_ack);
        chk("model q", q0, m_q);
        chk("model q_bar", qb0, e_qb);
        chk("model grant_id", gid0, m_gid);
        chk("model busy", busy0, (m_pend || m_wait > 0));
        chk("model wr_count", wc0, m_cnt);
    endtask

    // One cycle of dut0: check, log any ack, clock, then the acked requester drops req.
    task automatic step();
        logic [3:0] seen;
        int id;
        #1;
        check_model();
        seen = ack0;
        id   = 0;
        if (seen != 4'b0000) begin
            for (int i = 0; i < 4; i++) if (seen[i]) id = i;
            g_id.push_back(id);
            g_cyc.push_back(cyc_n);
            $display("txn cyc=%0d grant=%0d ack=%b wr_count_before=%0d", cyc_n, id, seen, wc0);
        end
        @(posedge clk);
        model_step();
        #1;
        if (seen != 4'b0000) g_q.push_back(q0);
        req = req & ~seen;
    endtask

    task automatic run_until_grant(int budget, output int id);
        int n0;
        n0 = g_id.size();
        for (int k = 0; k < budget && g_id.size() == n0; k++) step();
        if (g_id.size() == n0) begin
            total++; bad++;
            $display("FAIL grant timeout: got none expected a grant within %0d cycles", budget);
            id = -1;
        end else begin
            id = g_id[n0];
        end
    endtask

    initial begin
        int id, idle_at, hold_start, n_ack, last;
        bit pend_chk;
        logic [3:0] exp_d, exp_q, nq;

        tv[0] = '{4'b0100, 4'hA, 4'b0000, 4'h0, 1'b0, 2'd0, 8'd0};
        tv[1] = '{4'b0100, 4'hA, 4'b0100, 4'h0, 1'b1, 2'd2, 8'd0};
        tv[2] = '{4'b0000, 4'hA, 4'b0000, 4'hA, 1'b1, 2'd2, 8'd1};
        tv[3] = '{4'b0000, 4'hA, 4'b0000, 4'hA, 1'b1, 2'd2, 8'd1};
        tv[4] = '{4'b0000, 4'hA, 4'b0000, 4'hA, 1'b0, 2'd2, 8'd1};

        rst = 1'b1; req = 4'h0; wd0 = 4'h0; wd1 = 4'h0; wd2 = 4'h0; wd3 = 4'h0;
        rst1 = 1'b1; req1_in = 4'h0; wd1_in = 4'h0;
        repeat (2) begin @(posedge clk); model_step(); end
        step();
        rst = 1'b0;
        #1;
        chk("reset q", q0, 4'h0);
        chk("reset q_bar", qb0, 4'hF);
        chk("reset wr_count", wc0, 8'd0);
        chk("reset grant_id", gid0, 2'd0);
        chk("reset busy", busy0, 1'b0);
        chk("reset ack", ack0, 4'b0000);

        // Single write from requester 2
        for (int i = 0; i < 5; i++) begin
            req = tv[i].req;
            wd2 = tv[i].wd2;
            #1;
            nq = ~tv[i].q;
            chk($sformatf("vec%0d ack", i), ack0, tv[i].ack);
            chk($sformatf("vec%0d q", i), q0, tv[i].q);
            chk($sformatf("vec%0d q_bar", i), qb0, nq);
            chk($sformatf("vec%0d busy", i), busy0, tv[i].busy);
            chk($sformatf("vec%0d grant_id", i), gid0, tv[i].gid);
            chk($sformatf("vec%0d wr_count", i), wc0, tv[i].wc);
            step();
        end

        // Round robin from a fresh reset
        rst = 1'b1; step(); rst = 1'b0;
        wd0 = 4'h1; wd1 = 4'h2; wd2 = 4'h3; wd3 = 4'h4;
        g_id.delete(); g_cyc.delete(); g_q.delete();
        req = 4'b1111;
        for (int k = 0; k < 60 && g_id.size() < 4; k++) step();
        chk("rr grant count", g_id.size(), 4);
        if (g_id.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("rr grant%0d id", i), g_id[i], i);
                chk($sformatf("rr grant%0d q", i), g_q[i], i + 1);
                if (i > 0) chk($sformatf("rr spacing%0d", i), g_cyc[i] - g_cyc[i-1], 2 + H);
            end
        end

        // Fairness between 3 and 0
        req = 4'b1001;
        run_until_grant(20, id);
        chk("fair after 3", id, 0);
        req = 4'b1001;
        run_until_grant(20, id);
        chk("fair after 0", id, 3);

        // A request raised during HOLD waits for IDLE
        hold_start = cyc_n;
        chk("hold entered", busy0, 1'b1);
        req = 4'b0010;
        idle_at = -1;
        id = g_id.size();
        for (int k = 0; k < 20 && g_id.size() == id; k++) begin
            if (!busy0 && idle_at < 0) idle_at = cyc_n;
            step();
        end
        chk("hold grant seen", g_id.size(), id + 1);
        if (g_id.size() == id + 1) begin
            chk("hold grant id", g_id[id], 1);
            chk("hold idle after H", idle_at - hold_start, H);
            chk("hold ack one after idle", g_cyc[id] - idle_at, 1);
        end

        // Reset landing on LOAD suppresses the write
        for (int k = 0; k < 20 && busy0; k++) step();
        chk("pre-load idle", busy0, 1'b0);
        wd0 = 4'h7;
        req = 4'b0001;
        step();
        rst = 1'b1;
        #1;
        chk("rst-in-load ack", ack0, 4'b0000);
        step();
        rst = 1'b0;
        req = 4'b0000;
        #1;
        chk("rst-in-load q", q0, 4'h0);
        chk("rst-in-load wr_count", wc0, 8'd0);
        req = 4'b1111;
        run_until_grant(20, id);
        chk("rst-in-load rr_ptr", id, 0);

        // Random traffic against the model
        for (int k = 0; k < 400; k++) begin
            rst = ($urandom_range(0, 49) == 0);
            req = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) req = 4'b0000;
            wd0 = 4'($urandom); wd1 = 4'($urandom); wd2 = 4'($urandom); wd3 = 4'($urandom);
            step();
        end
        rst = 1'b0;

        // Counter wrap with HOLD_CYCLES=0: requester 1 back to back
        @(posedge clk); #1;
        rst1 = 1'b0;
        chk("wrap reset wr_count", wc1, 8'd0);
        chk("wrap reset q_bar", qb1, 4'hF);
        req1_in  = 4'b0010;
        wd1_in   = 4'h3;
        exp_q    = 4'h0;
        exp_d    = 4'h0;
        n_ack    = 0;
        last     = -1;
        pend_chk = 1'b0;
        for (int c = 0; c < 600 && n_ack < 256; c++) begin
            @(posedge clk); #1;
            if (pend_chk) begin
                exp_q = exp_d;
                chk("wrap q", q1, exp_d);
                chk("wrap wr_count", wc1, n_ack[7:0]);
                pend_chk = 1'b0;
                wd1_in = 4'(n_ack * 7 + 3);
            end
            nq = ~exp_q;
            chk("wrap q_bar", qb1, nq);
            if (ack1 != 4'b0000) begin
                chk("wrap ack", ack1, 4'b0010);
                if (last >= 0) chk("wrap spacing", c - last, 2);
                last = c;
                n_ack++;
                exp_d = wd1_in;
                pend_chk = 1'b1;
            end
        end
        @(posedge clk); #1;
        chk("wrap writes", n_ack, 256);
        chk("wrap final q", q1, exp_d);
        chk("wrap final wr_count", wc1, 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
